mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, SHALL set the request address width.
REQ-002 Parameter DATA_WIDTH, default 64, SHALL set the read and write data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, SHALL set the watchdog limit in cycles; used only when ARB_TIMEOUT_EN is defined.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 if_req_valid  input  1  fetch request valid.
REQ-007 if_req_ready  output  1  fetch request accepted this cycle.
REQ-008 if_req_addr  input  ADDR_WIDTH  fetch address (pc).
REQ-009 if_resp_valid  output  1  one-cycle fetch response pulse.
REQ-010 ls_req_valid  input  1  load/store request valid.
REQ-011 ls_req_ready  output  1  load/store request accepted this cycle.
REQ-012 ls_req_addr  input  ADDR_WIDTH  load/store address.
REQ-013 ls_req_wen  input  1  1 = store, 0 = load.
REQ-014 ls_req_wdata  input  DATA_WIDTH  store data.
REQ-015 ls_req_wdt  input  4  one-hot access width: byte, half, word, dword.
REQ-016 ls_resp_valid  output  1  one-cycle load/store response pulse.
REQ-017 resp_data  output  DATA_WIDTH  response data for whichever resp_valid is high.
REQ-018 resp_err  output  1  response error flag, qualified by either resp_valid.
REQ-019 mem_req_valid / mem_req_ready  output / input  1 each  memory request handshake.
REQ-020 mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wdt  outputs  ADDR_WIDTH / 1 / DATA_WIDTH / 4  captured request fields.
REQ-021 mem_resp_valid / mem_resp_data  inputs  1 / DATA_WIDTH  memory response; one response per accepted request, including stores.

Function
REQ-022 The FSM SHALL have states IDLE, REQ and WAIT, plus a 1-bit owner register (IF or LS).
REQ-023 In IDLE:
  - The grant SHALL use fixed priority, LS over IF.
  - The winner's req_ready SHALL be high combinationally in the same cycle; the loser's SHALL be 0.
  - Both ready outputs SHALL be 0 in REQ and WAIT.
REQ-024 On a valid&&ready handshake:
  - The address, wen, wdata and wdt SHALL be captured into holding registers.
  - Owner SHALL be recorded and the state SHALL move to REQ.
  - Fetch requests SHALL capture wen=0, wdt=dword and wdata=0.
REQ-025 In REQ:
  - mem_req_valid SHALL be 1 and all mem_req_* fields SHALL be held stable.
  - The state SHALL hold in REQ until mem_req_ready=1, then move to WAIT.
REQ-026 In WAIT, when mem_resp_valid=1:
  - The owner's resp_valid SHALL pulse high in the next cycle only.
  - resp_data SHALL carry mem_resp_data for a load or fetch, and 0 for a store.
  - resp_err SHALL be 0.
  - The state SHALL return to IDLE.
REQ-027 mem_resp_valid in IDLE or REQ SHALL be ignored.
REQ-028 Minimum latency SHALL be 3 cycles from accept to resp_valid: accept at cycle t, mem handshake at t+1, mem response at t+2, resp_valid at t+3.
REQ-029 A new request SHALL be acceptable in the same cycle resp_valid is high (back-to-back).
REQ-030 Simultaneous if_req_valid and ls_req_valid in IDLE SHALL grant LS; IF SHALL be granted on the next IDLE cycle if still valid.
REQ-031 resp_data SHALL hold its last value when no resp_valid is high.

Reset
REQ-032 While rst=0, and asynchronously on assertion:
  - state SHALL be IDLE and owner SHALL be IF.
  - All outputs and holding registers SHALL be 0, and the watchdog counter SHALL be cleared.
REQ-033 Reset mid-transaction SHALL abandon it without any response; a mem_resp_valid arriving after reset release SHALL be ignored.

Configuration
REQ-034 With ARB_TIMEOUT_EN defined:
  - A counter SHALL clear on accept and increment each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES, the owner's resp_valid SHALL pulse with resp_err=1 and resp_data=0.
  - mem_req_valid SHALL drop and the state SHALL return to IDLE.
REQ-035 Without ARB_TIMEOUT_EN, no counter SHALL exist, resp_err SHALL be tied 0, and the FSM SHALL wait indefinitely.

Verification
REQ-036 Fetch only: if_req_addr=0x80000000, mem_req_ready=1, response 0x00100073 after 1 cycle -> if_resp_valid pulses at cycle t+3 with resp_data=0x00100073, resp_err=0.
REQ-037 Simultaneous if_req_valid and ls_req_valid (load 0x80001000): ls_req_ready=1 and if_req_ready=0 at t; LS response served first; IF accepted at the cycle of ls_resp_valid.
REQ-038 Store wdata=0xDEADBEEF, wdt=word, mem_req_ready held 0 for 5 cycles: mem_req_* stay stable for those 5 cycles; ls_resp_valid follows with resp_data=0.
REQ-039 rst=0 asserted in WAIT, then a mem_resp_valid after release: no resp_valid pulse; FSM stays IDLE.
REQ-040 ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, no mem response: resp_valid pulses with resp_err=1 and resp_data=0 on the 8th cycle after accept; next request accepted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority (LS over IF) arbiter in front of a single-outstanding memory port.
// Optional response watchdog is built when ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_resp_valid,
    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic [ADDR_WIDTH-1:0] ls_req_addr,
    input  logic                  ls_req_wen,
    input  logic [DATA_WIDTH-1:0] ls_req_wdata,
    input  logic [3:0]            ls_req_wdt,
    output logic                  ls_resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]            mem_req_wdt,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);

    localparam int unsigned      WDT_W     = 4;
    localparam logic [WDT_W-1:0] WDT_DWORD = WDT_W'(4'b1000);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner_ls;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wen;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [WDT_W-1:0]      r_wdt;
    logic                  r_mem_req_valid;
    logic                  r_if_resp_valid;
    logic                  r_ls_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_resp_err;

    logic w_accept;
    logic w_grant_ls;
    logic w_issue_done;
    logic w_resp;
    logic w_tmo;
    logic w_tmo_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Decided one cycle early so the registered pulse lands TIMEOUT_CYCLES cycles after accept.
    assign w_tmo_hit = (r_state != S_IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state != S_IDLE) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_grant_ls   = 1'b0;
        w_issue_done = 1'b0;
        w_resp       = 1'b0;
        w_tmo        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ls_req_valid) begin
                    w_accept    = 1'b1;
                    w_grant_ls  = 1'b1;
                    w_state_nxt = S_REQ;
                end else if (if_req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_tmo_hit) begin
                    w_resp      = 1'b1;
                    w_tmo       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (mem_req_ready) begin
                    w_issue_done = 1'b1;
                    w_state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    w_resp      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_resp      = 1'b1;
                    w_tmo       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding registers, memory request and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner_ls      <= 1'b0;
            r_addr          <= '0;
            r_wen           <= 1'b0;
            r_wdata         <= '0;
            r_wdt           <= '0;
            r_mem_req_valid <= 1'b0;
            r_if_resp_valid <= 1'b0;
            r_ls_resp_valid <= 1'b0;
            r_resp_data     <= '0;
            r_resp_err      <= 1'b0;
        end else begin
            r_if_resp_valid <= 1'b0;
            r_ls_resp_valid <= 1'b0;
            if (w_accept) begin
                r_owner_ls      <= w_grant_ls;
                r_mem_req_valid <= 1'b1;
                if (w_grant_ls) begin
                    r_addr  <= ls_req_addr;
                    r_wen   <= ls_req_wen;
                    r_wdata <= ls_req_wdata;
                    r_wdt   <= ls_req_wdt;
                end else begin
                    r_addr  <= if_req_addr;
                    r_wen   <= 1'b0;
                    r_wdata <= '0;
                    r_wdt   <= WDT_DWORD;
                end
            end
            if (w_issue_done) begin
                r_mem_req_valid <= 1'b0;
            end
            if (w_resp) begin
                r_mem_req_valid <= 1'b0;
                r_if_resp_valid <= ~r_owner_ls;
                r_ls_resp_valid <= r_owner_ls;
                r_resp_err      <= w_tmo;
                r_resp_data     <= (w_tmo || r_wen) ? '0 : mem_resp_data;
            end
        end
    end

    // Grant is visible combinationally only in IDLE and never while reset is held.
    assign ls_req_ready  = rst & w_accept & w_grant_ls;
    assign if_req_ready  = rst & w_accept & ~w_grant_ls;

    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_addr;
    assign mem_req_wen   = r_wen;
    assign mem_req_wdata = r_wdata;
    assign mem_req_wdt   = r_wdt;
    assign if_resp_valid = r_if_resp_valid;
    assign ls_resp_valid = r_ls_resp_valid;
    assign resp_data     = r_resp_data;
    assign resp_err      = r_resp_err;

endmodule
